// File: rtl/sr_cond_pkg.sv
// Shared types and constants for the SR request conditioner.
// Holds the FSM state encoding, priority selectors and counter sizing.
package sr_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PULSE   = 2'b01,
    HOLDOFF = 2'b10
  } state_t;

  localparam bit SET_WINS = 1'b1;
  localparam bit CLR_WINS = 1'b0;

  // Width needed to count up to n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sr_input_debouncer.sv
// Two-flop synchroniser plus debounce counter for one raw request line.
// Emits a one-cycle req on each debounced 0->1 transition.
module sr_input_debouncer
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic req
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic [CW-1:0] cnt;

  // Synchronise, count consecutive disagreement, flip and flag rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
      req   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      req   <= 1'b0;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= sync2;
        cnt <= '0;
        req <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_request_conditioner.sv
// Turns raw set/clear requests into clean, exclusive s/r pulses.
// s and r are registered and can never be high together.
module sr_request_conditioner
  import sr_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter bit SET_PRIORITY    = CLR_WINS
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic clr_raw,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam int PW = cnt_w(PULSE_CYCLES);
  localparam int HW = cnt_w(HOLDOFF_CYCLES);
  localparam logic [PW-1:0] PLAST = PW'(PULSE_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLDOFF_CYCLES - 1);

  logic set_req;
  logic clr_req;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_n;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_n;
  logic          pend_set;
  logic          pend_set_n;
  logic          pend_clr;
  logic          pend_clr_n;
  logic          s_n;
  logic          r_n;
  logic          conflict_n;
  logic          want_s;
  logic          want_c;

  sr_input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set (
    .clk(clk),
    .rst(rst),
    .raw(set_raw),
    .req(set_req)
  );

  sr_input_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr (
    .clk(clk),
    .rst(rst),
    .raw(clr_raw),
    .req(clr_req)
  );

  assign want_s = set_req | pend_set;
  assign want_c = clr_req | pend_clr;
  assign busy   = (state != IDLE);

  // Next-state, pending-flag and output decisions.
  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    hcnt_n     = hcnt;
    s_n        = s;
    r_n        = r;
    conflict_n = 1'b0;
    pend_set_n = pend_set | set_req;
    pend_clr_n = pend_clr | clr_req;
    unique case (state)
      IDLE: begin
        s_n    = 1'b0;
        r_n    = 1'b0;
        pcnt_n = '0;
        hcnt_n = '0;
        if (want_s && want_c) begin
          conflict_n = 1'b1;
          pend_set_n = 1'b0;
          pend_clr_n = 1'b0;
          state_n    = PULSE;
          if (SET_PRIORITY == SET_WINS) s_n = 1'b1;
          else                          r_n = 1'b1;
        end else if (want_s) begin
          pend_set_n = 1'b0;
          s_n        = 1'b1;
          state_n    = PULSE;
        end else if (want_c) begin
          pend_clr_n = 1'b0;
          r_n        = 1'b1;
          state_n    = PULSE;
        end
      end
      PULSE: begin
        if (pcnt == PLAST) begin
          s_n     = 1'b0;
          r_n     = 1'b0;
          pcnt_n  = '0;
          state_n = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      HOLDOFF: begin
        s_n = 1'b0;
        r_n = 1'b0;
        if (hcnt == HLAST) begin
          hcnt_n  = '0;
          state_n = IDLE;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      default: begin
        s_n     = 1'b0;
        r_n     = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // State, counters, pending flags and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      hcnt     <= '0;
      pend_set <= 1'b0;
      pend_clr <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      state    <= state_n;
      pcnt     <= pcnt_n;
      hcnt     <= hcnt_n;
      pend_set <= pend_set_n;
      pend_clr <= pend_clr_n;
      s        <= s_n;
      r        <= r_n;
      conflict <= conflict_n;
    end
  end

endmodule

// File: tb/tb_sr_request_conditioner.sv
// Directed bench for sr_request_conditioner across four parameter sets.
// Expected pulse timing is hand-derived from edge 0 = first raw sample.
module tb_sr_request_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] set_raw = '0;
  logic [3:0] clr_raw = '0;
  logic [3:0] s;
  logic [3:0] r;
  logic [3:0] busy;
  logic [3:0] conflict;
  logic       q;
  int         errors = 0;
  int         checks = 0;
  int         pw [4] = '{1, 1, 2, 4};
  int         run [4] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  sr_request_conditioner u0 (
    .clk(clk), .rst(rst), .set_raw(set_raw[0]), .clr_raw(clr_raw[0]),
    .s(s[0]), .r(r[0]), .busy(busy[0]), .conflict(conflict[0])
  );

  sr_request_conditioner #(.SET_PRIORITY(1)) u1 (
    .clk(clk), .rst(rst), .set_raw(set_raw[1]), .clr_raw(clr_raw[1]),
    .s(s[1]), .r(r[1]), .busy(busy[1]), .conflict(conflict[1])
  );

  sr_request_conditioner #(.PULSE_CYCLES(2), .HOLDOFF_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .set_raw(set_raw[2]), .clr_raw(clr_raw[2]),
    .s(s[2]), .r(r[2]), .busy(busy[2]), .conflict(conflict[2])
  );

  sr_request_conditioner #(.PULSE_CYCLES(4)) u3 (
    .clk(clk), .rst(rst), .set_raw(set_raw[3]), .clr_raw(clr_raw[3]),
    .s(s[3]), .r(r[3]), .busy(busy[3]), .conflict(conflict[3])
  );

  // Downstream SR flip-flop fed by u0.
  always @(posedge clk or posedge rst) begin
    if (rst)       q <= 1'b0;
    else if (s[0]) q <= 1'b1;
    else if (r[0]) q <= 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    set_raw = '0;
    clr_raw = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_s", 32'(s), 0);
    chk("rst_r", 32'(r), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_conflict", 32'(conflict), 0);
    rst = 1'b0;
  endtask

  function automatic logic bval(input int k);
    return (k <= 2) || (k == 4) || (k == 5);
  endfunction

  initial begin
    // 1: clean set, defaults
    do_reset();
    set_raw[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t1_s", s[0], (k == 6));
      chk("t1_r", r[0], 0);
      chk("t1_busy", busy[0], (k >= 6 && k <= 8));
      chk("t1_conflict", conflict[0], 0);
    end
    chk("t1_q", q, 1);

    // 2: bounce rejection, then a clean hold
    do_reset();
    clr_raw[0] = bval(0);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("t2_bounce_r", r[0], 0);
      clr_raw[0] = bval(k + 1);
    end
    clr_raw[0] = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      chk("t2_hold_r", r[0], (k == 6));
      chk("t2_hold_s", s[0], 0);
      if (k == 9) clr_raw[0] = 1'b0;
    end

    // 3: simultaneous requests, clear wins on u0, set wins on u1
    do_reset();
    set_raw[1:0] = 2'b11;
    clr_raw[1:0] = 2'b11;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("t3_u0_s", s[0], 0);
      chk("t3_u0_r", r[0], (k == 6));
      chk("t3_u0_conflict", conflict[0], (k == 6));
      chk("t3_u1_s", s[1], (k == 6));
      chk("t3_u1_r", r[1], 0);
      chk("t3_u1_conflict", conflict[1], (k == 6));
    end

    // 4: clear becomes pending during holdoff (PULSE=2, HOLDOFF=3)
    do_reset();
    set_raw[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 3) clr_raw[2] = 1'b1;
      chk("t4_s", s[2], (k == 6 || k == 7));
      chk("t4_r", r[2], (k == 12 || k == 13));
      chk("t4_conflict", conflict[2], 0);
    end

    // 5a: reset mid-pulse with raw still high (PULSE=4)
    do_reset();
    set_raw[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t5_pre_s", s[3], (k >= 6));
    end
    rst = 1'b1;
    #1;
    chk("t5_async_s", s[3], 0);
    chk("t5_async_busy", busy[3], 0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      chk("t5_again_s", s[3], (k >= 6 && k <= 9));
    end

    // 5b: reset mid-pulse with raw dropped
    do_reset();
    set_raw[3] = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    set_raw[3] = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5b_async_s", s[3], 0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("t5b_s", s[3], 0);
      chk("t5b_busy", busy[3], 0);
    end

    // 6: random toggles, exclusivity and pulse width on all four
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        chk("t6_excl", 32'(s[i] & r[i]), 0);
        if (s[i] | r[i]) begin
          run[i]++;
        end else if (run[i] != 0) begin
          chk("t6_width", run[i], pw[i]);
          run[i] = 0;
        end
        if ($urandom_range(0, 15) == 0) set_raw[i] = ~set_raw[i];
        if ($urandom_range(0, 15) == 0) clr_raw[i] = ~clr_raw[i];
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
